// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Purpose  : Receives an 8N1 serial byte stream and packs bytes
//            little-endian into 32-bit words. Each word is presented with
//            a one-cycle write strobe and its byte address. After
//            WORD_COUNT words the image is complete: done rises and stays
//            high until reset, and the receiver then ignores the line.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            rx        - asynchronous serial input, idle high, LSB first
//            data_out  - most recently assembled word (held between strobes)
//            addr_out  - byte address of data_out (4 * word index)
//            wen       - one-cycle strobe, data_out/addr_out valid with it
//            done      - image complete (sticky until reset)
//            frame_err - sticky, set when a stop bit was sampled low
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int WORD_COUNT = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] data_out,
  output logic [31:0] addr_out,
  output logic        wen,
  output logic        done,
  output logic        frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [29:0]      C_LAST_WORD = 30'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer and start-arming
  logic       rx_meta_q, rx_sync_q;
  logic [1:0] rdy_q;     // fills with ones after reset; sync flops then hold real samples
  logic       armed_q;   // a genuine high level has been seen since reset

  // Receiver
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             wait_q, wait_d;   // bad stop bit: waiting for line to go high
  logic             accept_w;
  logic             ferr_set_w;

  // Word assembly
  logic [1:0]  byte_idx_q;
  logic [23:0] buf_q;
  logic [29:0] word_idx_q;
  logic        last_q;
  logic [31:0] data_q, addr_q;
  logic        wen_q, done_q, ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rdy_q     <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rdy_q     <= {rdy_q[0], 1'b1};
      if (rdy_q[1] && rx_sync_q) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    wait_d     = wait_q;
    accept_w   = 1'b0;
    ferr_set_w = 1'b0;
    if (done_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          bit_d  = '0;
          wait_d = 1'b0;
          if (armed_q && !rx_sync_q) state_d = START;
        end
        START: begin
          if (cnt_q == C_CNT_HALF) begin
            cnt_d   = '0;
            // still low at mid start bit: real start, otherwise a glitch
            state_d = rx_sync_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (wait_q) begin
            if (rx_sync_q) begin
              state_d = IDLE;
              wait_d  = 1'b0;
            end
          end else if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            if (rx_sync_q) begin
              accept_w = 1'b1;
              state_d  = IDLE;
            end else begin
              ferr_set_w = 1'b1;
              wait_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      buf_q      <= '0;
      word_idx_q <= '0;
      last_q     <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= done_q | (wen_q & last_q);
      if (ferr_set_w) ferr_q <= 1'b1;
      if (accept_w) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0:    buf_q[7:0]   <= shift_q;
          2'd1:    buf_q[15:8]  <= shift_q;
          2'd2:    buf_q[23:16] <= shift_q;
          default: begin
            data_q     <= {shift_q, buf_q};
            addr_q     <= {word_idx_q, 2'b00};
            wen_q      <= 1'b1;
            last_q     <= (word_idx_q == C_LAST_WORD);
            word_idx_q <= word_idx_q + 30'd1;
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign addr_out  = addr_q;
  assign wen       = wen_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Purpose  : Self-checking bench for uart_loader at 10 clocks per bit and a
//            two-word image. Table of four-byte words with expected results,
//            plus hand sequences for reset, glitch, framing error and reset
//            in the middle of a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [31:0] data_out, addr_out;
  logic        wen, done, frame_err;

  int checks   = 0;
  int failures = 0;

  // strobe monitor
  int          wen_cnt   = 0;
  int          wen_wide  = 0;
  logic        wen_prev  = 1'b0;
  logic        done_at_wen = 1'b0;
  logic        done_after  = 1'b0;
  logic        grab_after  = 1'b0;

  uart_loader #(.CLK_FREQ(100), .BAUD(10), .WORD_COUNT(2)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .addr_out(addr_out),
    .wen(wen), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (grab_after) done_after <= done;
    grab_after <= wen;
    if (wen) begin
      wen_cnt     <= wen_cnt + 1;
      done_at_wen <= done;
    end
    if (wen && wen_prev) wen_wide <= wen_wide + 1;
    wen_prev <= wen;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic        pre_reset;
    logic [7:0]  b [4];
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic        exp_done;
    int          exp_wens;
    logic        chk_done_edge;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int w0;

    vecs[0] = '{1'b1, '{8'h78, 8'h56, 8'h34, 8'h12}, 32'h12345678, 32'h0, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b0, '{8'hEF, 8'hBE, 8'hAD, 8'hDE}, 32'hDEADBEEF, 32'h4, 1'b1, 1, 1'b1};
    vecs[2] = '{1'b0, '{8'h11, 8'h22, 8'h33, 8'h44}, 32'hDEADBEEF, 32'h4, 1'b1, 0, 1'b0};
    vecs[3] = '{1'b1, '{8'h11, 8'hEE, 8'hFF, 8'hC0}, 32'hC0FFEE11, 32'h0, 1'b0, 1, 1'b0};

    do_reset();
    chk("reset data_out", data_out, 32'h0);
    chk("reset addr_out", addr_out, 32'h0);
    chk("reset wen", {31'b0, wen}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset frame_err", {31'b0, frame_err}, 32'h0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].pre_reset) do_reset();
      w0 = wen_cnt;
      for (int k = 0; k < 4; k++) send_byte(vecs[v].b[k], 1'b1);
      repeat (20) @(negedge clk);
      chk($sformatf("vec%0d wen count", v), wen_cnt - w0, vecs[v].exp_wens);
      chk($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_data);
      chk($sformatf("vec%0d addr_out", v), addr_out, vecs[v].exp_addr);
      chk($sformatf("vec%0d done", v), {31'b0, done}, {31'b0, vecs[v].exp_done});
      chk($sformatf("vec%0d frame_err", v), {31'b0, frame_err}, 32'h0);
      if (vecs[v].chk_done_edge) begin
        chk($sformatf("vec%0d done during wen", v), {31'b0, done_at_wen}, 32'h0);
        chk($sformatf("vec%0d done after wen", v), {31'b0, done_after}, 32'h1);
      end
    end

    // short low glitch on idle line: no byte, receiver still usable
    do_reset();
    w0 = wen_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch wen count", wen_cnt - w0, 0);
    chk("glitch frame_err", {31'b0, frame_err}, 32'h0);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    chk("post-glitch wen count", wen_cnt - w0, 1);
    chk("post-glitch data_out", data_out, 32'h12345678);

    // framing error: bad byte dropped, flag sticky, byte count not advanced
    do_reset();
    w0 = wen_cnt;
    send_byte(8'hAA, 1'b0);
    repeat (5) @(negedge clk);
    chk("ferr after bad stop", {31'b0, frame_err}, 32'h1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    chk("ferr sticky", {31'b0, frame_err}, 32'h1);
    chk("ferr wen count", wen_cnt - w0, 1);
    chk("ferr data_out", data_out, 32'h12345678);
    chk("ferr addr_out", addr_out, 32'h0);

    // reset after two bytes of a word discards them
    do_reset();
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    do_reset();
    w0 = wen_cnt;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    repeat (20) @(negedge clk);
    chk("midword rst wen count", wen_cnt - w0, 1);
    chk("midword rst data_out", data_out, 32'h04030201);
    chk("midword rst addr_out", addr_out, 32'h0);

    chk("wen single-cycle", wen_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, giving the serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
REQ-003 The block SHALL have parameter WORD_COUNT, default 16384, giving the number of 32-bit words per image before done.
- Ports (name, direction, width, meaning):
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-007 data_out  output  32  most recently assembled word.
REQ-008 addr_out  output  32  byte address of data_out.
REQ-009 wen  output  1  one-cycle strobe; data_out/addr_out are valid in that cycle.
REQ-010 done  output  1  image complete; drives CPU clock/memory-port selection downstream.
REQ-011 frame_err  output  1  sticky flag: a stop bit was sampled low.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 Receiver FSM SHALL have states IDLE, START, DATA, STOP with a bit-timing counter 0..CLKS_PER_BIT-1.
REQ-014 IDLE->START on synchronized rx low; counter cleared.
REQ-015 START: at count CLKS_PER_BIT/2, rx low -> DATA with counter cleared; rx high -> IDLE (glitch rejected, no byte).
REQ-016 DATA: sample rx every CLKS_PER_BIT clocks (mid-bit), shift in LSB first; after 8th sample -> STOP.
REQ-017 STOP: after CLKS_PER_BIT clocks sample rx; high -> byte accepted; low -> byte discarded, frame_err set to 1 until reset, FSM waits in STOP until rx high, then IDLE.
REQ-018 Accepted bytes SHALL be packed little-endian: byte k (0..3) of each group into data bits [8k+7:8k].
REQ-019 On the 4th accepted byte, data_out SHALL update and wen SHALL pulse high exactly one cycle, one clock after the stop-bit sample.
REQ-020 addr_out SHALL equal 4*word_index during the wen pulse; word_index starts at 0 and increments by 1 after each wen.
REQ-021 When the wen pulse for word_index == WORD_COUNT-1 fires, done SHALL go high the next cycle and stay high until reset.
REQ-022 While done is high, the receiver SHALL ignore rx; no further wen, no frame_err changes.
REQ-023 Byte counter SHALL wrap 3->0 on each word; discarded bytes SHALL NOT advance it.
REQ-024 data_out and addr_out SHALL hold their values between wen pulses.

Reset
REQ-025 rst high SHALL immediately force FSM=IDLE, counters=0, data_out=0, addr_out=0, wen=0, done=0, frame_err=0, synchronizer flops=1.
REQ-026 rst asserted mid-byte or mid-word SHALL discard partial byte/word; after release the next start bit begins byte 0 of word 0.
REQ-027 First valid start detection SHALL require synchronized rx high for at least one cycle after reset release.

Verification (CLK_FREQ=100, BAUD=10 -> 10 clk/bit, WORD_COUNT=2)
REQ-028 Bytes 0x78,0x56,0x34,0x12 -> one wen with data_out=0x12345678, addr_out=0x0, done=0, frame_err=0.
REQ-029 Bytes 0xEF,0xBE,0xAD,0xDE after REQ-028 -> wen with data_out=0xDEADBEEF, addr_out=0x4; done=1 next cycle; extra bytes give no wen.
REQ-030 3-clock low pulse on idle rx -> no byte, no wen, FSM back to IDLE.
REQ-031 Byte 0xAA with stop bit low, then 0x78,0x56,0x34,0x12 -> frame_err=1 sticky; single wen with data_out=0x12345678, addr_out=0x0.
REQ-032 rst asserted after two bytes of a word, then four bytes 0x01,0x02,0x03,0x04 -> wen with data_out=0x04030201, addr_out=0x0.
REQ-033 rst while done=1 -> done=0, addr_out=0, loader accepts a new image.
